i2s_tx: RTL and testbench

- I2S master transmitter for the DAC output path; the transmit-side counterpart of the PCM1808 capture interface.
- Derives SCKI/BCK/LRCK from the 12 MHz system clock: SCKI = 12 MHz, BCK = 3 MHz, Fs = 46.875 kHz.
- Accepts stereo 24-bit samples over a valid/ready handshake into a one-deep holding buffer.
- Serialises each sample MSB-first in standard I2S format: 32-bit slots, 1-BCK data delay, data changes on the BCK falling edge.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_clkgen.sv | 42 ++++
 rtl/i2s_tx.sv | 119 +++++++++++
 tb/tb_i2s_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Constants and sample types shared by the I2S TX and RX paths.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int DATA_W      = 24;
  localparam int SLOT_W      = 32;
  localparam int FRAME_BCK   = 64;
  localparam int CLK_PER_BCK = 4;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clkgen
// Purpose  : Free-running prescaler producing SCKI/BCK/LRCK plus bit and frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCK_DIV_LOG2 = $clog2(CLK_PER_BCK),
  parameter int SLOT_LOG2    = $clog2(FRAME_BCK)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 scki,
  output logic                 bck,
  output logic                 lrck,
  output logic                 bit_strobe,
  output logic                 frame_strobe,
  output logic [SLOT_LOG2-1:0] slot_next
);

  localparam int CNT_W = SLOT_LOG2 + BCK_DIV_LOG2;

  logic [CNT_W-1:0] r_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_p <= '0;
    else        r_p <= r_p + CNT_W'(1);
  end

  // Strobes flag the edge on which BCK falls / the frame wraps, so consumers
  // update their registers on exactly that edge.
  assign scki         = clk;
  assign bck          = r_p[BCK_DIV_LOG2-1];
  assign lrck         = r_p[CNT_W-1];
  assign bit_strobe   = &r_p[BCK_DIV_LOG2-1:0];
  assign frame_strobe = &r_p;
  assign slot_next    = r_p[CNT_W-1:BCK_DIV_LOG2] + SLOT_LOG2'(1);

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S master transmitter with a one-deep sample holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int DATA_W       = 24,
  parameter int SLOT_W       = 32,
  parameter int BCK_DIV_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              scki,
  output logic              bck,
  output logic              lrck,
  output logic              sdout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int SLOT_LOG2 = $clog2(2 * SLOT_W);
  localparam int IDX_W     = SLOT_LOG2 - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

  logic                 w_bit_strobe;
  logic                 w_frame_strobe;
  logic [SLOT_LOG2-1:0] w_slot_next;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_pos;
  logic [DATA_W-1:0]    w_word;
  logic                 w_bit;
  logic                 w_xfer;

  logic                 r_pend_full;
  logic [DATA_W-1:0]    r_pend_l;
  logic [DATA_W-1:0]    r_pend_r;
  logic [DATA_W-1:0]    r_act_l;
  logic [DATA_W-1:0]    r_act_r;
  logic                 r_sdout;
  logic                 r_frame_start;
  logic                 r_underrun;

  i2s_clkgen #(
    .BCK_DIV_LOG2 (BCK_DIV_LOG2),
    .SLOT_LOG2    (SLOT_LOG2)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .scki         (scki),
    .bck          (bck),
    .lrck         (lrck),
    .bit_strobe   (w_bit_strobe),
    .frame_strobe (w_frame_strobe),
    .slot_next    (w_slot_next)
  );

  assign in_ready = reset & ~r_pend_full;
  assign w_xfer   = in_valid & in_ready;

  // A bypass at the frame wrap consumes the transfer directly into the active
  // frame, so the holding buffer is only written off the wrap edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_full   <= 1'b0;
      r_pend_l      <= '0;
      r_pend_r      <= '0;
      r_act_l       <= '0;
      r_act_r       <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_frame_strobe;
      r_underrun    <= 1'b0;
      if (w_frame_strobe) begin
        if (r_pend_full) begin
          r_act_l     <= r_pend_l;
          r_act_r     <= r_pend_r;
          r_pend_full <= 1'b0;
        end else if (in_valid) begin
          r_act_l <= in_left;
          r_act_r <= in_right;
        end else begin
          r_act_l    <= '0;
          r_act_r    <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_pend_l    <= in_left;
        r_pend_r    <= in_right;
        r_pend_full <= 1'b1;
      end
    end
  end

  // Slot index within the channel: 0 is the 1-BCK delay, 1..DATA_W carry MSB..LSB.
  always_comb begin
    w_idx  = w_slot_next[IDX_W-1:0];
    w_word = w_slot_next[SLOT_LOG2-1] ? r_act_r : r_act_l;
    w_pos  = LAST_IDX - w_idx;
    w_bit  = 1'b0;
    if (w_idx != '0 && w_idx <= LAST_IDX) w_bit = w_word[w_pos];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_sdout <= 1'b0;
    else if (w_bit_strobe) r_sdout <= w_bit;
  end

  assign sdout       = r_sdout;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Purpose  : Directed and randomized stimulus for i2s_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  localparam int DW = 24;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_left;
  logic [DW-1:0] in_right;
  logic          in_valid;
  logic          in_ready;
  logic          scki;
  logic          bck;
  logic          lrck;
  logic          sdout;
  logic          frame_start;
  logic          underrun;

  int total = 0;
  int bad   = 0;

  // Reference model state: clk edges since release, accepted pairs not yet
  // loaded, and the pair currently being serialised.
  int              k = 0;
  logic [2*DW-1:0] q[$];
  logic [DW-1:0]   cur_l = '0;
  logic [DW-1:0]   cur_r = '0;
  logic            exp_fs = 1'b0;
  logic            exp_ur = 1'b0;
  bit              last_acc;
  int              ur_cnt;
  logic [DW-1:0]   ctr;

  i2s_tx dut (
    .clk         (clk),
    .reset       (reset),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .scki        (scki),
    .bck         (bck),
    .lrck        (lrck),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Standard I2S: slot 0 of each half is the delay bit, then MSB first.
  function automatic logic ref_bit(input int s);
    int idx;
    logic [DW-1:0] w;
    idx = s % 32;
    w   = (s < 32) ? cur_l : cur_r;
    if (idx >= 1 && idx <= DW) return w[DW - idx];
    return 1'b0;
  endfunction

  task automatic check_all();
    int p;
    p = k % 256;
    chk("scki",        scki,        1'b0);
    chk("bck",         bck,         1'((p / 2) % 2));
    chk("lrck",        lrck,        1'(p / 128));
    chk("frame_start", frame_start, exp_fs);
    chk("underrun",    underrun,    exp_ur);
    chk("in_ready",    in_ready,    reset && (q.size() == 0));
    chk("sdout",       sdout,       ref_bit(p / 4));
  endtask

  task automatic tick();
    last_acc = reset && in_valid && (q.size() == 0);
    @(posedge clk);
    if (!reset) begin
      k = 0;
      q.delete();
      cur_l  = '0;
      cur_r  = '0;
      exp_fs = 1'b0;
      exp_ur = 1'b0;
      last_acc = 1'b0;
    end else begin
      if (last_acc) q.push_back({in_left, in_right});
      exp_fs = (k % 256 == 255);
      exp_ur = 1'b0;
      if (exp_fs) begin
        if (q.size() != 0) begin
          {cur_l, cur_r} = q.pop_front();
        end else begin
          cur_l  = '0;
          cur_r  = '0;
          exp_ur = 1'b1;
        end
      end
      k++;
    end
    @(negedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;

    // Reset state
    repeat (5) tick();

    // Known pattern presented before the first frame load
    reset    = 1'b1;
    in_valid = 1'b1;
    in_left  = 24'h800001;
    in_right = 24'h7FFFFE;
    tick();
    in_valid = 1'b0;
    while (k < 512) tick();

    // Idle: three silent frames, each flagged as an underrun
    ur_cnt = 0;
    while (k < 1280) begin
      tick();
      if (underrun === 1'b1) ur_cnt++;
    end
    total++;
    assert (ur_cnt === 3) else begin
      bad++;
      $error("FAIL idle_underruns observed=%0d expected=%0d", ur_cnt, 3);
    end

    // Continuous valid with an incrementing counter
    ctr      = 24'h000001;
    in_valid = 1'b1;
    in_left  = ctr;
    in_right = ctr + 24'd1;
    repeat (1024) begin
      tick();
      if (last_acc) begin
        ctr      = ctr + 24'd2;
        in_left  = ctr;
        in_right = ctr + 24'd1;
      end
    end
    in_valid = 1'b0;

    // Sparse random traffic
    repeat (1536) begin
      in_valid = ($urandom_range(0, 299) == 0);
      in_left  = DW'($urandom);
      in_right = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;

    // Bypass: valid arrives exactly on the wrap cycle with nothing pending
    for (int i = 0; i < 600 && !(k % 256 == 255 && q.size() == 0); i++) tick();
    in_valid = 1'b1;
    in_left  = DW'($urandom);
    in_right = DW'($urandom);
    tick();
    chk("bypass_frame_start", frame_start, 1'b1);
    chk("bypass_no_underrun", underrun,    1'b0);
    in_valid = 1'b0;

    // Same wrap-cycle stimulus with a sample already pending
    while (k % 256 != 100) tick();
    in_valid = 1'b1;
    in_left  = DW'($urandom);
    in_right = DW'($urandom);
    tick();
    in_valid = 1'b0;
    while (k % 256 != 255) tick();
    chk("pend_ready_low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_left  = DW'($urandom);
    in_right = DW'($urandom);
    tick();
    tick();
    in_valid = 1'b0;
    repeat (300) tick();

    // Asynchronous reset in the middle of the right slot
    while (k % 256 != 160) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_bck",         bck,         1'b0);
    chk("arst_lrck",        lrck,        1'b0);
    chk("arst_sdout",       sdout,       1'b0);
    chk("arst_in_ready",    in_ready,    1'b0);
    chk("arst_frame_start", frame_start, 1'b0);
    chk("arst_underrun",    underrun,    1'b0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
